// File: rtl/uart_fifo_tx.sv
// uart_fifo_tx: transmit-side FIFO that sits in front of the UART TX core.
// The CPU pushes bytes with wr. They are queued in a circular buffer and
// handed to the transmitter one at a time using a tx_start pulse and
// tx_done level handshake. d_in drives the transmitter data input directly.
//
// Optional feature macro: UART_FIFO_TX_OVERRUN_EN
//   defined   -> adds the output port 'overrun', a sticky flag that is set
//                by any write attempted while the FIFO is full
//   undefined -> no overrun port; writes while full are silently dropped
//
// state       | meaning
// ------------+------------------------------------------------------------
// IDLE        | no frame in progress; loads d_in from the FIFO head if data
// START       | tx_start high for exactly this cycle
// ESPERO_TX   | frame in progress; pops the head on the first tx_done high
// ESPERO_BAJA | frame finished; waits for tx_done to fall before next frame
module uart_fifo_tx #(
    parameter int DATA_BITS = 8,
    parameter int ADDR_BITS = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [DATA_BITS-1:0] w_data,
    input  logic                 wr,
    output logic                 tx_full,
    output logic                 tx_empty,
    output logic [ADDR_BITS:0]   tx_count,
    output logic [DATA_BITS-1:0] d_in,
    output logic                 tx_start,
    input  logic                 tx_done
`ifdef UART_FIFO_TX_OVERRUN_EN
    ,
    output logic                 overrun
`endif
);

    localparam int                 DEPTH   = 1 << ADDR_BITS;
    localparam logic [ADDR_BITS:0] DEPTH_C = (ADDR_BITS + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        START       = 2'd1,
        ESPERO_TX   = 2'd2,
        ESPERO_BAJA = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [DATA_BITS-1:0]   mem_q [DEPTH];
    logic [ADDR_BITS-1:0]   wp_q, wp_d;
    logic [ADDR_BITS-1:0]   rp_q, rp_d;
    logic [ADDR_BITS:0]     count_q, count_d;
    logic [DATA_BITS-1:0]   d_in_q, d_in_d;
    logic                   push;
    logic                   pop;
    logic                   load_d;

    // Flags are a pure decode of the registered count, so a push while full
    // is rejected even if a pop happens in the same cycle.
    assign tx_full  = (count_q == DEPTH_C);
    assign tx_empty = (count_q == '0);
    assign tx_count = count_q;
    assign d_in     = d_in_q;
    assign push     = wr & ~tx_full;

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------

    // Data array write port; contents need no reset because the count
    // guards every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wp_q] <= w_data;
        end
    end

    // Pointer and occupancy next-state; pointers wrap modulo the depth.
    always_comb begin
        wp_d    = wp_q;
        rp_d    = rp_q;
        count_d = count_q;
        if (push) begin
            wp_d = wp_q + 1'b1;
        end
        if (pop) begin
            rp_d = rp_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wp_q    <= '0;
            rp_q    <= '0;
            count_q <= '0;
        end else begin
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            count_q <= count_d;
        end
    end

    // ------------------------------------------------------------------
    // Transmit sequencer
    // ------------------------------------------------------------------

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; tx_done is only looked at while a frame is out.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (!tx_empty) begin
                    state_d = START;
                end
            end
            START: begin
                state_d = ESPERO_TX;
            end
            ESPERO_TX: begin
                if (tx_done) begin
                    state_d = ESPERO_BAJA;
                end
            end
            ESPERO_BAJA: begin
                if (!tx_done) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output decode: start strobe, head load and head pop per state.
    // A tx_done level already high on entry to ESPERO_TX pops at once.
    always_comb begin
        tx_start = 1'b0;
        load_d   = 1'b0;
        pop      = 1'b0;
        case (state_q)
            IDLE:      load_d   = ~tx_empty;
            START:     tx_start = 1'b1;
            ESPERO_TX: pop      = tx_done;
            default:   ;
        endcase
    end

    // ------------------------------------------------------------------
    // Transmitter data register
    // ------------------------------------------------------------------

    // d_in only changes on the IDLE->START load and otherwise holds, even
    // after the FIFO has drained.
    always_comb begin
        d_in_d = d_in_q;
        if (load_d) begin
            d_in_d = mem_q[rp_q];
        end
    end

    // Transmitter data register; cleared immediately by reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            d_in_q <= '0;
        end else begin
            d_in_q <= d_in_d;
        end
    end

`ifdef UART_FIFO_TX_OVERRUN_EN
    logic overrun_q;

    assign overrun = overrun_q;

    // Sticky record of any write attempted against a full FIFO.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overrun_q <= 1'b0;
        end else if (wr && tx_full) begin
            overrun_q <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_uart_fifo_tx.sv
// Testbench for uart_fifo_tx. A queue-based reference model tracks the
// accepted bytes, the frame in progress and the expected start pulses.
module tb_uart_fifo_tx;

    localparam int DEPTH = 4;

    logic       clk     = 1'b0;
    logic       reset_n = 1'b0;
    logic       wr      = 1'b0;
    logic       tx_done = 1'b0;
    logic [7:0] w_data  = 8'h00;
    logic       tx_full;
    logic       tx_empty;
    logic       tx_start;
    logic [2:0] tx_count;
    logic [7:0] d_in;
`ifdef UART_FIFO_TX_OVERRUN_EN
    logic       overrun;
    logic       m_ovr;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    // reference model
    logic [7:0] m_q[$];
    logic [7:0] m_acc[$];
    logic [7:0] m_sent[$];
    logic [7:0] m_din;
    logic       m_active;
    logic       m_fresh;
    logic       m_popped;
    logic       m_ready;

    uart_fifo_tx #(
        .DATA_BITS(8),
        .ADDR_BITS(2)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .w_data   (w_data),
        .wr       (wr),
        .tx_full  (tx_full),
        .tx_empty (tx_empty),
        .tx_count (tx_count),
        .d_in     (d_in),
        .tx_start (tx_start),
        .tx_done  (tx_done)
`ifdef UART_FIFO_TX_OVERRUN_EN
        ,
        .overrun  (overrun)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_din    = 8'h00;
        m_active = 1'b0;
        m_fresh  = 1'b0;
        m_popped = 1'b0;
        m_ready  = 1'b0;
`ifdef UART_FIFO_TX_OVERRUN_EN
        m_ovr    = 1'b0;
`endif
    endtask

    task automatic clear_logs();
        m_acc.delete();
        m_sent.delete();
    endtask

    // One clock: update the model at the rising edge from the inputs the
    // DUT sampled, then check every output at the falling edge.
    task automatic step();
        logic push, pop, fin, exp_start;
        @(posedge clk);
        if (reset_n) begin
            push = wr && (m_q.size() < DEPTH);
`ifdef UART_FIFO_TX_OVERRUN_EN
            if (wr && m_q.size() == DEPTH) m_ovr = 1'b1;
`endif
            fin  = m_active && m_popped && !tx_done;
            pop  = m_active && !m_fresh && !m_popped && tx_done;
            m_fresh = 1'b0;
            if (pop) begin
                void'(m_q.pop_front());
                m_popped = 1'b1;
            end
            if (push) begin
                m_q.push_back(w_data);
                m_acc.push_back(w_data);
            end
            if (fin) m_active = 1'b0;
        end
        @(negedge clk);
        // an idle sequencer that saw data one cycle ago is now starting
        exp_start = reset_n && !m_active && m_ready;
        if (exp_start) begin
            m_active = 1'b1;
            m_fresh  = 1'b1;
            m_popped = 1'b0;
            m_din    = m_q[0];
        end
        m_ready = reset_n && !m_active && (m_q.size() > 0);
        if (tx_start) m_sent.push_back(d_in);
        check("tx_start", tx_start, exp_start);
        check("tx_count", tx_count, m_q.size());
        check("tx_empty", tx_empty, m_q.size() == 0);
        check("tx_full", tx_full, m_q.size() == DEPTH);
        check("d_in", d_in, m_din);
`ifdef UART_FIFO_TX_OVERRUN_EN
        check("overrun", overrun, m_ovr);
`endif
    endtask

    // Act as a transmitter until every queued byte has been sent.
    task automatic drain();
        int i;
        wr = 1'b0;
        i  = 0;
        while ((m_q.size() > 0 || m_active) && i < 400) begin
            tx_done = ((i % 4) >= 2);
            step();
            i++;
        end
        tx_done = 1'b0;
        repeat (3) step();
        check("drain_timeout", i < 400, 1);
        check("drain_empty", tx_empty, 1);
    endtask

    task automatic compare_log(input string tag);
        check({tag, "_len"}, m_sent.size(), m_acc.size());
        for (int i = 0; i < m_sent.size() && i < m_acc.size(); i++) begin
            check({tag, "_byte"}, m_sent[i], m_acc[i]);
        end
    endtask

    initial begin
        logic [7:0] exp_fill [5];
        logic [7:0] exp_simul [3];
        int wr_pct;
        int done_pct;

        exp_fill  = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5};
        exp_simul = '{8'hA1, 8'hA2, 8'hA3};

        // reset held with a write request pending: nothing is stored
        model_reset();
        clear_logs();
        wr      = 1'b1;
        w_data  = 8'hA5;
        repeat (3) step();
        check("rst_empty", tx_empty, 1);
        check("rst_full", tx_full, 0);
        check("rst_count", tx_count, 0);
        check("rst_d_in", d_in, 0);
        reset_n = 1'b1;
        wr      = 1'b0;
        repeat (3) step();
        check("rst_post_empty", tx_empty, 1);

        // single byte: start two edges after the write, then pop on done
        clear_logs();
        wr     = 1'b1;
        w_data = 8'd50;
        step();
        wr = 1'b0;
        check("single_early", tx_start, 0);
        step();
        check("single_start", tx_start, 1);
        check("single_d_in", d_in, 8'd50);
        repeat (5) step();
        check("single_hold", tx_count, 1);
        tx_done = 1'b1;
        step();
        check("single_pop", tx_count, 0);
        step();
        tx_done = 1'b0;
        repeat (5) step();
        check("single_once", m_sent.size(), 1);
        check("single_d_in_hold", d_in, 8'd50);

        // fill and overflow: byte 1 in flight and popped, 2..5 fill the FIFO
        clear_logs();
        wr     = 1'b1;
        w_data = 8'd1;
        step();
        wr = 1'b0;
        step();
        step();
        tx_done = 1'b1;
        for (int i = 2; i <= 5; i++) begin
            wr     = 1'b1;
            w_data = 8'(i);
            step();
        end
        check("fill_full", tx_full, 1);
        check("fill_count", tx_count, 4);
        w_data = 8'd6;
        step();
        wr = 1'b0;
        check("fill_drop_count", tx_count, 4);
`ifdef UART_FIFO_TX_OVERRUN_EN
        check("fill_overrun", overrun, 1);
`endif
        drain();
        check("fill_len", m_sent.size(), 5);
        for (int i = 0; i < m_sent.size() && i < 5; i++) begin
            check("fill_byte", m_sent[i], exp_fill[i]);
        end

        // wrap-around: pairs of writes interleaved with draining
        clear_logs();
        for (int i = 0; i < 10; i += 2) begin
            wr     = 1'b1;
            w_data = 8'(8'h10 + i);
            step();
            w_data = 8'(8'h10 + i + 1);
            step();
            wr = 1'b0;
            drain();
        end
        check("wrap_len", m_sent.size(), 10);
        for (int i = 0; i < m_sent.size() && i < 10; i++) begin
            check("wrap_byte", m_sent[i], 8'(8'h10 + i));
        end

        // simultaneous push and pop leave the count unchanged
        clear_logs();
        wr     = 1'b1;
        w_data = 8'hA1;
        step();
        w_data = 8'hA2;
        step();
        wr = 1'b0;
        step();
        check("simul_pre", tx_count, 2);
        wr      = 1'b1;
        w_data  = 8'hA3;
        tx_done = 1'b1;
        step();
        wr = 1'b0;
        check("simul_count", tx_count, 2);
        drain();
        check("simul_len", m_sent.size(), 3);
        for (int i = 0; i < m_sent.size() && i < 3; i++) begin
            check("simul_byte", m_sent[i], exp_simul[i]);
        end

        // reset mid-frame discards everything at once
        clear_logs();
        wr = 1'b1;
        for (int i = 0; i < 3; i++) begin
            w_data = 8'(8'hB1 + i);
            step();
        end
        wr = 1'b0;
        step();
        check("midrst_pre", tx_count, 3);
        #2 reset_n = 1'b0;
        #1;
        check("midrst_count", tx_count, 0);
        check("midrst_d_in", d_in, 0);
        check("midrst_empty", tx_empty, 1);
        check("midrst_start", tx_start, 0);
        model_reset();
        step();
        reset_n = 1'b1;
        repeat (6) step();
        check("midrst_no_start", m_sent.size(), 1);

        // randomized traffic against the model
        clear_logs();
        for (int blk = 0; blk < 4; blk++) begin
            wr_pct   = (blk == 0) ? 20 : (blk == 1) ? 80 : (blk == 2) ? 50 : 95;
            done_pct = (blk == 0) ? 60 : (blk == 1) ? 30 : (blk == 2) ? 50 : 10;
            for (int c = 0; c < 400; c++) begin
                wr      = ($urandom_range(0, 99) < wr_pct);
                w_data  = 8'($urandom);
                tx_done = ($urandom_range(0, 99) < done_pct);
                step();
            end
        end
        drain();
        compare_log("rand");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
